// File: rtl/axilite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axilite_regfile
// Brief    : AXI4-Lite slave register file with read-only hw_in lanes, SLVERR
//            on illegal accesses and per-register write pulses. Defining
//            AXILITE_REGFILE_WSTRB_EN enables byte-strobe writes.
// Revision : 1.0 - initial release
// ============================================================================
module axilite_regfile #(
    parameter int                DATA_W  = 32,
    parameter int                NREG    = 4,
    parameter logic [NREG-1:0]   RO_MASK = '0,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [31:0]            cbus_awaddr,
    input  logic [2:0]             cbus_awprot,
    input  logic                   cbus_awvalid,
    output logic                   cbus_awready,
    input  logic [DATA_W-1:0]      cbus_wdata,
    input  logic [DATA_W/8-1:0]    cbus_wstrb,
    input  logic                   cbus_wvalid,
    output logic                   cbus_wready,
    output logic [1:0]             cbus_bresp,
    output logic                   cbus_bvalid,
    input  logic                   cbus_bready,
    input  logic [31:0]            cbus_araddr,
    input  logic [2:0]             cbus_arprot,
    input  logic                   cbus_arvalid,
    output logic                   cbus_arready,
    output logic [DATA_W-1:0]      cbus_rdata,
    output logic [1:0]             cbus_rresp,
    output logic                   cbus_rvalid,
    input  logic                   cbus_rready,
    output logic [NREG*DATA_W-1:0] reg_q,
    input  logic [NREG*DATA_W-1:0] hw_in,
    output logic [NREG-1:0]        wr_pulse
);

    localparam int          c_STRB_W = DATA_W / 8;
    localparam logic [31:0] c_NREG   = 32'(NREG);
    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;

    localparam logic [0:0]  c_W_IDLE = 1'b0;
    localparam logic [0:0]  c_W_RESP = 1'b1;
    localparam logic [0:0]  c_R_IDLE = 1'b0;
    localparam logic [0:0]  c_R_RESP = 1'b1;

    logic [0:0]        r_wstate;
    logic [0:0]        w_wstate_nxt;
    logic [0:0]        r_rstate;
    logic [0:0]        w_rstate_nxt;
    logic              r_out_en;

    logic              r_aw_held;
    logic [31:0]       r_aw_addr;
    logic              r_w_held;
    logic [DATA_W-1:0] r_w_data;
    logic [c_STRB_W-1:0] r_w_strb;

    logic [1:0]        r_bresp;
    logic [1:0]        r_rresp;
    logic [DATA_W-1:0] r_rdata;
    logic [NREG-1:0]   r_wr_pulse;

    logic              w_commit;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic [NREG-1:0]   w_wr_sel;
    logic [DATA_W-1:0] w_wmask;
    logic [DATA_W-1:0] w_rd_src [NREG];
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_legal;
    logic              w_unused_ok;

    // Keeps every ready low while reset is asserted and for the first edge after.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_out_en <= 1'b0;
        else       r_out_en <= 1'b1;
    end

    assign cbus_awready = r_out_en && (r_wstate == c_W_IDLE) && !r_aw_held;
    assign cbus_wready  = r_out_en && (r_wstate == c_W_IDLE) && !r_w_held;
    assign cbus_arready = r_out_en && (r_rstate == c_R_IDLE);
    assign cbus_bvalid  = (r_wstate == c_W_RESP);
    assign cbus_rvalid  = (r_rstate == c_R_RESP);
    assign cbus_bresp   = r_bresp;
    assign cbus_rresp   = r_rresp;
    assign cbus_rdata   = r_rdata;
    assign wr_pulse     = r_wr_pulse;

    assign w_aw_hs  = cbus_awvalid && cbus_awready;
    assign w_w_hs   = cbus_wvalid && cbus_wready;
    assign w_ar_hs  = cbus_arvalid && cbus_arready;
    assign w_commit = (r_wstate == c_W_IDLE) && r_aw_held && r_w_held;

    // ---------------------------------------------------------------- write FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate <= c_W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            c_W_IDLE: if (w_commit)    w_wstate_nxt = c_W_RESP;
            c_W_RESP: if (cbus_bready) w_wstate_nxt = c_W_IDLE;
            default:                   w_wstate_nxt = c_W_IDLE;
        endcase
    end

    // AW and W are captured independently; both slots free up on commit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= cbus_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= cbus_wdata;
                r_w_strb <= cbus_wstrb;
            end
        end
    end

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            w_wr_sel[i] = w_commit && (r_aw_addr == 32'(i)) && !RO_MASK[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bresp    <= c_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_wr_sel;
            if (w_commit) r_bresp <= (|w_wr_sel) ? c_OKAY : c_SLVERR;
        end
    end

`ifdef AXILITE_REGFILE_WSTRB_EN
    always_comb begin
        w_wmask = '0;
        for (int k = 0; k < c_STRB_W; k++) begin
            w_wmask[k*8 +: 8] = {8{r_w_strb[k]}};
        end
    end
`else
    assign w_wmask = '1;
`endif

    // -------------------------------------------------------- register storage
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_q[i*DATA_W +: DATA_W] = '0;
            assign w_rd_src[i]               = hw_in[i*DATA_W +: DATA_W];
        end else begin : g_rw
            logic [DATA_W-1:0] r_val;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_val <= RST_VAL;
                end else if (w_wr_sel[i]) begin
                    r_val <= (r_val & ~w_wmask) | (r_w_data & w_wmask);
                end
            end
            assign reg_q[i*DATA_W +: DATA_W] = r_val;
            assign w_rd_src[i]               = r_val;
        end
    end

    // ----------------------------------------------------------------- read FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate <= c_R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_R_IDLE: if (w_ar_hs)     w_rstate_nxt = c_R_RESP;
            c_R_RESP: if (cbus_rready) w_rstate_nxt = c_R_IDLE;
            default:                   w_rstate_nxt = c_R_IDLE;
        endcase
    end

    assign w_rd_legal = (cbus_araddr < c_NREG);

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (cbus_araddr == 32'(i)) w_rd_data = w_rd_src[i];
        end
    end

    // Sampling on the AR edge returns pre-commit contents on a same-edge write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= '0;
            r_rresp <= c_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_legal ? c_OKAY : c_SLVERR;
        end
    end

    assign w_unused_ok = ^{cbus_awprot, cbus_arprot, hw_in, r_w_strb};

endmodule
`default_nettype wire

// File: tb/tb_axilite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axilite_regfile
// Brief    : Self-checking bench for axilite_regfile (table, hand-written
//            corner sequences and randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axilite_regfile;

    localparam int          DATA_W = 32;
    localparam int          NREG   = 4;
    localparam logic [3:0]  RO     = 4'b1000;
    localparam logic [31:0] RSTV   = 32'h0000_A5A5;
`ifdef AXILITE_REGFILE_WSTRB_EN
    localparam logic [31:0] WS1_EXP = 32'hFF00_FF00;
    localparam logic [31:0] WS2_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] WS1_EXP = 32'h0000_0000;
    localparam logic [31:0] WS2_EXP = 32'h1111_2222;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [31:0]   cbus_awaddr;
    logic [2:0]    cbus_awprot;
    logic          cbus_awvalid;
    logic          cbus_awready;
    logic [31:0]   cbus_wdata;
    logic [3:0]    cbus_wstrb;
    logic          cbus_wvalid;
    logic          cbus_wready;
    logic [1:0]    cbus_bresp;
    logic          cbus_bvalid;
    logic          cbus_bready;
    logic [31:0]   cbus_araddr;
    logic [2:0]    cbus_arprot;
    logic          cbus_arvalid;
    logic          cbus_arready;
    logic [31:0]   cbus_rdata;
    logic [1:0]    cbus_rresp;
    logic          cbus_rvalid;
    logic          cbus_rready;
    logic [127:0]  reg_q;
    logic [127:0]  hw_in;
    logic [3:0]    wr_pulse;

    axilite_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .RO_MASK(RO),
        .RST_VAL(RSTV)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cbus_awaddr (cbus_awaddr),
        .cbus_awprot (cbus_awprot),
        .cbus_awvalid(cbus_awvalid),
        .cbus_awready(cbus_awready),
        .cbus_wdata  (cbus_wdata),
        .cbus_wstrb  (cbus_wstrb),
        .cbus_wvalid (cbus_wvalid),
        .cbus_wready (cbus_wready),
        .cbus_bresp  (cbus_bresp),
        .cbus_bvalid (cbus_bvalid),
        .cbus_bready (cbus_bready),
        .cbus_araddr (cbus_araddr),
        .cbus_arprot (cbus_arprot),
        .cbus_arvalid(cbus_arvalid),
        .cbus_arready(cbus_arready),
        .cbus_rdata  (cbus_rdata),
        .cbus_rresp  (cbus_rresp),
        .cbus_rvalid (cbus_rvalid),
        .cbus_rready (cbus_rready),
        .reg_q       (reg_q),
        .hw_in       (hw_in),
        .wr_pulse    (wr_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_reg [NREG];

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: a plain array of register values plus the access rules.
    function automatic logic [127:0] exp_regq();
        logic [127:0] q;
        q = '0;
        for (int i = 0; i < NREG; i++) if (!RO[i]) q[i*32 +: 32] = m_reg[i];
        return q;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] m;
        if (a >= 32'(NREG)) return 2'b10;
        if (RO[a[1:0]]) return 2'b10;
        m = 32'hFFFF_FFFF;
`ifdef AXILITE_REGFILE_WSTRB_EN
        for (int k = 0; k < 4; k++) if (!s[k]) m[k*8 +: 8] = 8'h00;
`else
        if (s === 4'bxxxx) m = 32'hFFFF_FFFF;
`endif
        m_reg[a[1:0]] = (m_reg[a[1:0]] & ~m) | (d & m);
        return 2'b00;
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        if (a >= 32'(NREG)) begin
            d = '0; r = 2'b10;
        end else if (RO[a[1:0]]) begin
            d = hw_in[a[1:0]*32 +: 32]; r = 2'b00;
        end else begin
            d = m_reg[a[1:0]]; r = 2'b00;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awready"}, cbus_awready, 1'b0);
        chk({tag, "_wready"},  cbus_wready,  1'b0);
        chk({tag, "_arready"}, cbus_arready, 1'b0);
        chk({tag, "_bvalid"},  cbus_bvalid,  1'b0);
        chk({tag, "_rvalid"},  cbus_rvalid,  1'b0);
        chk({tag, "_bresp"},   cbus_bresp,   2'b00);
        chk({tag, "_rresp"},   cbus_rresp,   2'b00);
        chk({tag, "_rdata"},   cbus_rdata,   32'h0);
        chk({tag, "_wr_pulse"}, wr_pulse,    4'h0);
        chk({tag, "_reg_q"},   reg_q,        exp_regq());
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        logic [1:0]   exp_resp;
        logic [3:0]   exp_pulse;
        logic [127:0] pre_q;
        pre_q = exp_regq();
        cbus_awaddr = addr; cbus_wdata = data; cbus_wstrb = strb; cbus_bready = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            cbus_awvalid = !aw_done && (cyc >= aw_dly);
            cbus_wvalid  = !w_done && (cyc >= w_dly);
            if (aw_done) chk("awready_after_capture", cbus_awready, 1'b0);
            if (w_done)  chk("wready_after_capture", cbus_wready, 1'b0);
            if (aw_done || w_done) begin
                chk("no_early_bvalid", cbus_bvalid, 1'b0);
                chk("no_early_commit", reg_q, pre_q);
            end
            aw_hs = cbus_awvalid && cbus_awready;
            w_hs  = cbus_wvalid && cbus_wready;
            tick();
            cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
        end
        cbus_awvalid = 1'b0; cbus_wvalid = 1'b0;
        chk("aw_w_handshake", {aw_done, w_done}, 2'b11);
        chk("bvalid_not_yet", cbus_bvalid, 1'b0);
        chk("wr_pulse_not_yet", wr_pulse, 4'h0);
        exp_resp  = model_write(addr, data, strb);
        exp_pulse = (exp_resp == 2'b00) ? (4'b0001 << addr[1:0]) : 4'b0000;
        tick();
        chk("bvalid_latency", cbus_bvalid, 1'b1);
        chk("bresp", cbus_bresp, exp_resp);
        chk("wr_pulse", wr_pulse, exp_pulse);
        chk("reg_q_after_write", reg_q, exp_regq());
        resp = cbus_bresp;
        tick();
        chk("bvalid_clear", cbus_bvalid, 1'b0);
        chk("wr_pulse_clear", wr_pulse, 4'h0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic [31:0] ed;
        logic [1:0]  er;
        int cyc;
        bit hs;
        cbus_araddr = addr; cbus_arvalid = 1'b1; cbus_rready = 1'b1;
        cyc = 0; hs = 0; ed = '0; er = 2'b00;
        while (!hs && cyc < 20) begin
            if (cbus_arready) begin
                hs = 1;
                model_read(addr, ed, er);
            end
            tick();
            cyc++;
        end
        cbus_arvalid = 1'b0;
        chk("ar_handshake", hs, 1'b1);
        chk("rvalid_latency", cbus_rvalid, 1'b1);
        chk("rdata", cbus_rdata, ed);
        chk("rresp", cbus_rresp, er);
        data = cbus_rdata; resp = cbus_rresp;
        tick();
        chk("rvalid_clear", cbus_rvalid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd, old;
        int          cnt;

        vecs[0]  = '{1'b1, 32'd0,         32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b1, 32'd1,         32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vecs[2]  = '{1'b1, 32'd2,         32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 32'd3,         32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
        vecs[4]  = '{1'b0, 32'd0,         32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF};
        vecs[5]  = '{1'b0, 32'd1,         32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF};
        vecs[6]  = '{1'b0, 32'd2,         32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF};
        vecs[7]  = '{1'b0, 32'd3,         32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'd4,         32'h1357_9BDF, 4'hF, 2'b10, 32'h0};
        vecs[9]  = '{1'b0, 32'd4,         32'h0,         4'h0, 2'b10, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0101, 32'h2468_ACE0, 4'hF, 2'b10, 32'h0};
        vecs[11] = '{1'b0, 32'h8000_0002, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[12] = '{1'b1, 32'd1,         32'h0000_0000, 4'h5, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 32'd1,         32'h0,         4'h0, 2'b00, WS1_EXP};
        vecs[14] = '{1'b1, 32'd2,         32'h1111_2222, 4'h0, 2'b00, 32'h0};
        vecs[15] = '{1'b0, 32'd2,         32'h0,         4'h0, 2'b00, WS2_EXP};

        rstn = 1'b0;
        cbus_awaddr = '0; cbus_awprot = '0; cbus_awvalid = 1'b0;
        cbus_wdata = '0; cbus_wstrb = '0; cbus_wvalid = 1'b0; cbus_bready = 1'b0;
        cbus_araddr = '0; cbus_arprot = '0; cbus_arvalid = 1'b0; cbus_rready = 1'b0;
        hw_in = {32'hCAFE_F00D, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
        for (int i = 0; i < NREG; i++) m_reg[i] = RSTV;

        repeat (3) tick();
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (2) tick();

        // Table-driven directed vectors.
        for (int v = 0; v < 16; v++) begin
            if (vecs[v].is_wr) begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, 0, 0, resp);
                chk($sformatf("vec%0d_bresp", v), resp, vecs[v].exp_resp);
            end else begin
                do_read(vecs[v].addr, rd, resp);
                chk($sformatf("vec%0d_rresp", v), resp, vecs[v].exp_resp);
                chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            end
        end

        // W presented two cycles ahead of AW.
        do_write(32'd2, 32'h1234_5678, 4'hF, 2, 0, resp);
        chk("w_first_lane2", reg_q[95:64], 32'h1234_5678);

        // AR handshake on the same edge as a commit to the same register.
        old = m_reg[0];
        cbus_awaddr = 32'd0; cbus_wdata = 32'h0BAD_BEEF; cbus_wstrb = 4'hF; cbus_bready = 1'b1;
        cbus_awvalid = 1'b1; cbus_wvalid = 1'b1;
        chk("same_edge_aw_w_ready", {cbus_awready, cbus_wready}, 2'b11);
        tick();
        cbus_awvalid = 1'b0; cbus_wvalid = 1'b0;
        cbus_araddr = 32'd0; cbus_arvalid = 1'b1; cbus_rready = 1'b1;
        chk("same_edge_arready", cbus_arready, 1'b1);
        tick();
        cbus_arvalid = 1'b0;
        resp = model_write(32'd0, 32'h0BAD_BEEF, 4'hF);
        chk("same_edge_rdata_old", cbus_rdata, old);
        chk("same_edge_rvalid", cbus_rvalid, 1'b1);
        chk("same_edge_bvalid", cbus_bvalid, 1'b1);
        chk("same_edge_reg_q", reg_q, exp_regq());
        tick();
        chk("same_edge_done", {cbus_bvalid, cbus_rvalid}, 2'b00);

        // Back-to-back reads with arvalid and rready held high.
        cnt = 0;
        cbus_araddr = 32'd1; cbus_arvalid = 1'b1; cbus_rready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (cbus_rvalid) begin
                cnt++;
                chk("b2b_rdata", cbus_rdata, m_reg[1]);
            end
            tick();
        end
        cbus_arvalid = 1'b0;
        chk("b2b_read_count", cnt, 3);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            hw_in[127:96] = $urandom;
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), $urandom_range(0, 2), resp);
            else
                do_read(a, rd, resp);
        end

        // Hold bready low in W_RESP, then reset mid-response.
        cbus_awaddr = 32'd1; cbus_wdata = 32'h5555_AAAA; cbus_wstrb = 4'hF; cbus_bready = 1'b0;
        cbus_awvalid = 1'b1; cbus_wvalid = 1'b1;
        tick();
        cbus_awvalid = 1'b0; cbus_wvalid = 1'b0;
        tick();
        resp = model_write(32'd1, 32'h5555_AAAA, 4'hF);
        chk("hold_reg_q", reg_q, exp_regq());
        for (int c = 0; c < 5; c++) begin
            chk("hold_bvalid", cbus_bvalid, 1'b1);
            chk("hold_bresp", cbus_bresp, resp);
            tick();
        end
        rstn = 1'b0;
        #2;
        for (int i = 0; i < NREG; i++) m_reg[i] = RSTV;
        check_reset_outputs("mid_reset");
        tick();
        tick();
        rstn = 1'b1;
        repeat (2) tick();
        chk("post_reset_bvalid", cbus_bvalid, 1'b0);
        chk("post_reset_reg_q", reg_q, exp_regq());
        do_read(32'd1, rd, resp);
        chk("post_reset_read", rd, RSTV);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axilite_regfile.md
# axilite_regfile

Parametrised AXI4-Lite slave register file: NREG registers of DATA_W bits on the cbus control bus, with per-register read-only mapping to hardware inputs, SLVERR on illegal accesses, and a one-cycle write strobe per register to the fabric. It sits between the control-bus master and the datapath blocks that consume configuration and expose status.

## Interface
Parameters:
- DATA_W, 32, register and bus data width; multiple of 8
- NREG, 4, number of registers; 1..256
- RO_MASK, 0, NREG-bit mask; bit i set makes register i read-only, read from hw_in
- RST_VAL, 0, DATA_W-bit reset value of every writable register

Ports:
- clk  in  1  clock; all logic on the rising edge
- rstn  in  1  asynchronous, active-low reset
- cbus_awaddr  in  32  write word index
- cbus_awprot  in  3  ignored
- cbus_awvalid / cbus_awready  in / out  1  AW handshake
- cbus_wdata  in  DATA_W  write data
- cbus_wstrb  in  DATA_W/8  byte strobes
- cbus_wvalid / cbus_wready  in / out  1  W handshake
- cbus_bresp  out  2  00 OKAY, 10 SLVERR
- cbus_bvalid / cbus_bready  out / in  1  B handshake
- cbus_araddr  in  32  read word index
- cbus_arprot  in  3  ignored
- cbus_arvalid / cbus_arready  in / out  1  AR handshake
- cbus_rdata  out  DATA_W  read data
- cbus_rresp  out  2  00 OKAY, 10 SLVERR
- cbus_rvalid / cbus_rready  out / in  1  R handshake
- reg_q  out  NREG*DATA_W  register contents, register i at bits [i*DATA_W +: DATA_W]
- hw_in  in  NREG*DATA_W  read-only sources; only lanes with RO_MASK set are used
- wr_pulse  out  NREG  one-cycle pulse on an OKAY commit to register i

## Operation
- Addresses are word indices, not byte addresses. An access is legal iff the full 32-bit address < NREG.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, AW and W are captured independently into holding registers, in any order or together.
  - awready = W_IDLE & !aw_held; wready = W_IDLE & !w_held.
  - On the first edge with both held: commit, then bvalid=1 and state W_RESP; the holding registers clear.
  - The commit is a write to a legal, writable register with bresp OKAY and a wr_pulse. An out-of-range or RO_MASK register is not written, gives bresp SLVERR and no wr_pulse.
  - In W_RESP, bvalid and bresp are stable until the bready handshake, then the FSM returns to W_IDLE.
- Read FSM, states R_IDLE and R_RESP:
  - arready = R_IDLE.
  - On the AR handshake, rdata and rresp are registered and rvalid=1 in R_RESP.
  - rdata and rresp are held until the rready handshake, then R_IDLE.
  - Legal addresses give stored or hw_in data with OKAY; out-of-range gives rdata 0 with SLVERR.
- Read and write channels are fully independent and may be active in the same cycle.

## Timing
- Reset (rstn low, asynchronous):
  - all ready and valid outputs 0; bresp, rresp, rdata 0
  - reg_q = RST_VAL for writable lanes, 0 for RO lanes
  - wr_pulse 0
  - holding registers cleared; both FSMs to idle
- Reset mid-transaction abandons it: no commit, no response.
- After the last handshake of AW/W at edge N: commit and bvalid at edge N+1. reg_q shows the new value and wr_pulse is high for exactly the cycle after edge N+1.
- AR handshake at edge N: rvalid high after edge N, a 1-cycle read latency. Back-to-back reads sustain one per 2 cycles when rready is held high.
- A read handshake on the same edge as a write commit to the same register returns the old value.
- hw_in is sampled on the AR handshake edge.
- A new AW or W is not accepted while in W_RESP, so at most one write is outstanding.

## Configuration
- AXILITE_REGFILE_WSTRB_EN defined:
  - byte lane k of the target register is written only when wstrb[k] is 1.
  - wstrb 0 still commits with OKAY and wr_pulse, with contents unchanged.
- Not defined: wstrb is ignored and every commit writes all DATA_W bits.

## Test plan
- Reset, then write 0xFFFF_FFFF to indices 0..3 and read them back. Required: each bresp/rresp 00, rdata 0xFFFF_FFFF, wr_pulse[i] exactly one cycle per write.
- Present W two cycles before AW (data 0x1234_5678, index 2). Required: wready drops after capture, the write commits only after AW, and reg_q lane 2 = 0x1234_5678.
- Write and read index 4 with NREG=4. Required: bresp 10 with no reg_q change and no wr_pulse; rresp 10 with rdata 0.
- Set RO_MASK=4'b1000 and hw_in lane 3 = 0xCAFE_F00D. Required: a read of index 3 returns 0xCAFE_F00D OKAY; a write to index 3 gives SLVERR with no wr_pulse.
- With WSTRB_EN defined, reg 1 = 0xFFFF_FFFF, write 0x0000_0000 with wstrb 4'b0101. Required: reg 1 = 0xFF00_FF00. Without the macro: reg 1 = 0x0000_0000.
- Hold bready low for 5 cycles after bvalid, and pulse rstn low mid-W_RESP. Required: bvalid and bresp stable while waiting; after reset all outputs are at their reset values and reg_q = RST_VAL.
